vec_demux16b2: RTL and testbench

Burst-oriented 1-to-2 stream demultiplexer for the memory-to-memory vector datapath: the steering counterpart of the 2:1 16-bit operand mux. A command selects destination A or B and a vector length. The block then routes exactly that many 16-bit elements from one input stream to the chosen output through a registered valid/ready stage, drains it, and pulses `done`. It sits between the vector-element fetch path and the two writeback/operand sinks.

---
 rtl/vec_pkg.sv | 17 +
 rtl/stream_reg.sv | 27 ++
 rtl/vec_demux16b2.sv | 117 +++++++++++
 tb/tb_vec_demux16b2.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared state encodings, output-select codes and default widths for the
// vector-datapath steering blocks.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUTE = 2'b01,
    DRAIN = 2'b10
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LEN_W = 8;

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready output register: load wins over consume, so a
// same-cycle consume+load leaves the register full with the new element.
module stream_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_demux16b2.sv
// Burst-oriented 1-to-2 stream demultiplexer: a command picks output A or B
// and a length, then exactly that many elements are steered there.
module vec_demux16b2
  import vec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             busy,
  output logic             done
);

  state_e           state, state_next;
  logic [LEN_W-1:0] count, count_next;
  logic             sel_q, sel_next;
  logic             done_next;
  logic             x_valid, x_ready;
  logic             xfer, load_a, load_b;

  assign x_valid = (sel_q == SEL_B) ? b_valid : a_valid;
  assign x_ready = (sel_q == SEL_B) ? b_ready : a_ready;

  // busy is registered from the next state so it always equals (state != IDLE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sel_q <= SEL_A;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      sel_q <= sel_next;
      done  <= done_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    sel_next   = sel_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_next = 1'b1;
          end else begin
            sel_next   = cmd_sel;
            count_next = cmd_len;
            state_next = ROUTE;
          end
        end
      end
      ROUTE: begin
        if (xfer) begin
          count_next = count - LEN_W'(1);
          if (count == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (x_valid && x_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_ready depends only on the selected output register, never on in_valid
  always_comb begin
    cmd_ready = (state == IDLE);
    in_ready  = (state == ROUTE) && (!x_valid || x_ready);
    xfer      = in_valid && in_ready;
    load_a    = xfer && (sel_q == SEL_A);
    load_b    = xfer && (sel_q == SEL_B);
  end

  stream_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (in_data),
    .ready     (a_ready),
    .valid     (a_valid),
    .data      (a_data)
  );

  stream_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (in_data),
    .ready     (b_ready),
    .valid     (b_valid),
    .data      (b_data)
  );

endmodule

// File: tb/tb_vec_demux16b2.sv
// Randomized scoreboard bench for vec_demux16b2: expected elements are queued
// per destination when a command is issued and popped by a monitor on consume.
module tb_vec_demux16b2;

  localparam int WIDTH = 16;
  localparam int LEN_W = 8;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_sel = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             a_valid, b_valid;
  logic             a_ready = 1'b0, b_ready = 1'b0;
  logic [WIDTH-1:0] a_data, b_data;
  logic             busy, done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_seen = 0;
  int done_cyc = -1;
  bit track = 0;
  logic active_sel = 1'b0;
  logic [WIDTH-1:0] exp_a[$];
  logic [WIDTH-1:0] exp_b[$];
  bit stall_a = 0, stall_b = 0;
  logic [WIDTH-1:0] held_a = '0, held_b = '0;

  vec_demux16b2 #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink-side ready generator: 0 always, 1 the 1,0,0,1 pattern, 2 random, 3 never
  initial begin
    logic [3:0] pat;
    logic r;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: r = 1'b1;
        1: r = pat[3 - (cyc % 4)];
        2: r = 1'($urandom % 2);
        default: r = 1'b0;
      endcase
      a_ready = r;
      b_ready = r;
    end
  end

  // Monitor: pops the scoreboard on every consume and checks hold/steering rules
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (!rst) begin
      if (stall_a) begin
        checkOutput("a_hold_valid", 32'(a_valid), 32'd1);
        checkOutput("a_hold_data", 32'(a_data), 32'(held_a));
      end
      if (stall_b) begin
        checkOutput("b_hold_valid", 32'(b_valid), 32'd1);
        checkOutput("b_hold_data", 32'(b_data), 32'(held_b));
      end
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) checkOutput("a_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_a.pop_front();
          checkOutput("a_data", 32'(a_data), 32'(e));
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) checkOutput("b_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_b.pop_front();
          checkOutput("b_data", 32'(b_data), 32'(e));
        end
      end
      stall_a = a_valid && !a_ready;
      held_a  = a_data;
      stall_b = b_valid && !b_ready;
      held_b  = b_data;
      if (track) begin
        if (active_sel == SEL_A) begin
          checkOutput("b_valid_unselected", 32'(b_valid), 32'd0);
          if (a_valid && !a_ready) checkOutput("in_ready_stall_a", 32'(in_ready), 32'd0);
        end else begin
          checkOutput("a_valid_unselected", 32'(a_valid), 32'd0);
          if (b_valid && !b_ready) checkOutput("in_ready_stall_b", 32'(in_ready), 32'd0);
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        checkOutput("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end else begin
      stall_a = 0;
      stall_b = 0;
    end
  end

  // Issues one command and streams its elements; rmode selects sink behaviour,
  // dmode the data pattern (0: index+1, 1: index, 2: random)
  task automatic applyStimulus(input logic sel, input int len, input int rmode,
                               input int dmode, input bit gaps, input bit spurious);
    int c0, done_before, budget, exp_done;
    bit acc, timed;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] elems[$];
    for (int i = 0; i < len; i++) begin
      case (dmode)
        0: d = WIDTH'(i + 1);
        1: d = WIDTH'(i);
        default: d = WIDTH'($urandom);
      endcase
      elems.push_back(d);
    end
    timed = (rmode == 0) && !gaps;
    ready_mode = rmode;
    @(posedge clk);
    #1;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_sel = sel;
    cmd_len = LEN_W'(len);
    c0 = cyc;
    done_before = done_seen;
    exp_done = (len == 0) ? c0 + 1 : c0 + len + 2;
    @(posedge clk);
    active_sel = sel;
    track = 1;
    foreach (elems[i]) begin
      if (sel == SEL_A) exp_a.push_back(elems[i]);
      else exp_b.push_back(elems[i]);
    end
    #1;
    cmd_valid = 1'b0;
    if (len == 0) begin
      in_valid = 1'b1;
      in_data = WIDTH'($urandom);
      @(negedge clk);
      checkOutput("in_ready_zero_len", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data = elems[i];
      if (spurious && i == 1) begin
        cmd_valid = 1'b1;
        cmd_sel = ~sel;
        cmd_len = LEN_W'(7);
      end
      budget = 200;
      acc = 0;
      while (!acc && budget > 0) begin
        @(negedge clk);
        acc = in_ready;
        checkOutput("busy_route", 32'(busy), 32'd1);
        if (cmd_valid) checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        budget--;
      end
      if (!acc) checkOutput("in_timeout", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    budget = 1000;
    while (done_seen == done_before && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput("done_count", 32'(done_seen - done_before), 32'd1);
    if (timed) checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
    checkOutput("queue_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("done_count_after", 32'(done_seen - done_before), 32'd1);
    track = 0;
  endtask

  // Resets the block with element 3 of 5 still in the A register
  task automatic resetMidBurst();
    int done_before;
    ready_mode = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_sel = SEL_A;
    cmd_len = LEN_W'(5);
    done_before = done_seen;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(WIDTH'(16'h0A00 + i));
      in_valid = 1'b1;
      in_data = WIDTH'(16'h0A00 + i);
      @(negedge clk);
      checkOutput("in_ready_pre_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("a_valid_pre_reset", 32'(a_valid), 32'd1);
    rst = 1'b1;
    #1;
    exp_a.delete();
    checkOutput("a_valid_reset", 32'(a_valid), 32'd0);
    checkOutput("a_data_reset", 32'(a_data), 32'd0);
    checkOutput("cmd_ready_reset", 32'(cmd_ready), 32'd1);
    checkOutput("busy_reset", 32'(busy), 32'd0);
    checkOutput("done_reset", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("no_done_after_reset", 32'(done_seen - done_before), 32'd0);
  endtask

  initial begin
    $display("[TB] vec_demux16b2 bench starting");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_a_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_b_valid", 32'(b_valid), 32'd0);
    checkOutput("rst_a_data", 32'(a_data), 32'd0);
    checkOutput("rst_b_data", 32'(b_data), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(SEL_A, 4, 0, 0, 1'b0, 1'b0);
    applyStimulus(SEL_B, 3, 1, 2, 1'b0, 1'b0);
    applyStimulus(SEL_A, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(SEL_B, 255, 0, 1, 1'b0, 1'b0);
    checkOutput("max_burst_last", 32'(b_data), 32'h00FE);
    resetMidBurst();
    applyStimulus(SEL_A, 5, 0, 2, 1'b0, 1'b0);
    applyStimulus(SEL_A, 6, 0, 2, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'($urandom % 2), int'($urandom_range(1, 24)), int'($urandom_range(0, 2)),
                    2, 1'($urandom % 2), 1'($urandom % 2));
    end

    checkOutput("final_exp_a_empty", 32'(exp_a.size()), 32'd0);
    checkOutput("final_exp_b_empty", 32'(exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
